// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 single-wire frame reader.
package dht11_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START_LOW,
    WAIT_RESP,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK,
    ERROR
  } state_e;

  localparam int FRAME_BITS = 40;
  localparam int US_CNT_W   = 15;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS + 1);

  // Checksum byte the sensor should have sent: low 8 bits of the four data bytes.
  function automatic logic [7:0] frame_sum(input logic [FRAME_BITS-1:0] f);
    return f[39:32] + f[31:24] + f[23:16] + f[15:8];
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Microsecond prescaler: one-cycle tick every CLKS_PER_US clocks, restartable.
module dht11_us_tick #(
  parameter int CLKS_PER_US = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_US - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The tick does not look at clear_i, so the FSM can use it without a loop.
  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dht11_frame_reader.sv
// DHT11 single-wire master: issues the host start pulse, times the sensor
// response and 40 data bits, and publishes checksum-verified readings.
module dht11_frame_reader #(
  parameter int CLKS_PER_US   = 50,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 200,
  parameter int BIT_THRESH_US = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic       busy,
  output logic       data_valid,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic       checksum_err,
  output logic       timeout_err
);
  import dht11_pkg::*;

  localparam logic [US_CNT_W-1:0]  START_LAST   = US_CNT_W'(START_LOW_US - 1);
  localparam logic [US_CNT_W-1:0]  TIMEOUT_LAST = US_CNT_W'(TIMEOUT_US - 1);
  localparam logic [US_CNT_W-1:0]  BIT_THRESH   = US_CNT_W'(BIT_THRESH_US);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT     = BIT_CNT_W'(FRAME_BITS - 1);

  state_e                state_q, state_d;
  logic [1:0]            sync_q;
  logic                  line_prev_q;
  logic [US_CNT_W-1:0]   us_cnt_q, us_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  dht_oe_q, busy_q, data_valid_q, checksum_err_q, timeout_err_q;
  logic [7:0]            hum_int_q, hum_dec_q, temp_int_q, temp_dec_q;

  logic us_tick, state_change, line_rise, line_fall, sum_ok;
  logic in_sensor_phase, start_done, phase_timeout;

  assign line_fall       = line_prev_q & ~sync_q[1];
  assign line_rise       = ~line_prev_q & sync_q[1];
  assign state_change    = (state_d != state_q);
  assign sum_ok          = (frame_sum(shreg_q) == shreg_q[7:0]);
  assign start_done      = us_tick && (us_cnt_q == START_LAST);
  assign phase_timeout   = us_tick && (us_cnt_q == TIMEOUT_LAST);
  assign in_sensor_phase = state_q inside {WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH};

  dht11_us_tick #(
    .CLKS_PER_US (CLKS_PER_US)
  ) u_us_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (state_change),
    .tick_o  (us_tick)
  );

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;

    unique case (state_q)
      IDLE:      if (start)      state_d = START_LOW;
      START_LOW: if (start_done) state_d = WAIT_RESP;
      WAIT_RESP: if (line_fall)  state_d = RESP_LOW;
      RESP_LOW:  if (line_rise)  state_d = RESP_HIGH;
      RESP_HIGH: if (line_fall)  state_d = BIT_LOW;
      BIT_LOW:   if (line_rise)  state_d = BIT_HIGH;
      BIT_HIGH: begin
        if (line_fall) begin
          shreg_d   = {shreg_q[FRAME_BITS-2:0], (us_cnt_q > BIT_THRESH)};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = (bit_cnt_q == LAST_BIT) ? CHECK : BIT_LOW;
        end
      end
      CHECK, ERROR: begin
        shreg_d   = '0;
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A line edge in the same cycle wins over the timeout.
    if (in_sensor_phase && phase_timeout && (state_d == state_q)) state_d = ERROR;

    us_cnt_d = us_cnt_q + US_CNT_W'(us_tick);
    if (state_d != state_q) us_cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      line_prev_q <= 1'b1;
      us_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[0], dht_in};
      line_prev_q <= sync_q[1];
      us_cnt_q    <= us_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
    end
  end

  // Registered outputs; the async reset releases the line without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dht_oe_q       <= 1'b0;
      busy_q         <= 1'b0;
      data_valid_q   <= 1'b0;
      checksum_err_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      hum_int_q      <= 8'h00;
      hum_dec_q      <= 8'h00;
      temp_int_q     <= 8'h00;
      temp_dec_q     <= 8'h00;
    end else begin
      dht_oe_q       <= (state_d == START_LOW);
      busy_q         <= (state_d != IDLE);
      data_valid_q   <= (state_q == CHECK) && sum_ok;
      checksum_err_q <= (state_q == CHECK) && !sum_ok;
      timeout_err_q  <= (state_q == ERROR);
      if ((state_q == CHECK) && sum_ok) begin
        hum_int_q  <= shreg_q[39:32];
        hum_dec_q  <= shreg_q[31:24];
        temp_int_q <= shreg_q[23:16];
        temp_dec_q <= shreg_q[15:8];
      end
    end
  end

  assign dht_oe       = dht_oe_q;
  assign busy         = busy_q;
  assign data_valid   = data_valid_q;
  assign checksum_err = checksum_err_q;
  assign timeout_err  = timeout_err_q;
  assign hum_int      = hum_int_q;
  assign hum_dec      = hum_dec_q;
  assign temp_int     = temp_int_q;
  assign temp_dec     = temp_dec_q;

endmodule

// File: tb/tb_dht11_frame_reader.sv
// Directed bench for dht11_frame_reader with a behavioural DHT11 sensor model.
module tb_dht11_frame_reader;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       start    = 1'b0;
  logic       sensor_q = 1'b1;
  logic       dht_in;
  logic       dht_oe, busy, data_valid, checksum_err, timeout_err;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec;

  int   tests  = 0;
  int   failed = 0;
  int   dv_cnt = 0;
  int   ce_cnt = 0;
  int   to_cnt = 0;
  logic busy_at_dv = 1'b1;

  localparam logic [39:0] FRAME_A = 40'h37_00_19_00_50;
  localparam logic [39:0] FRAME_B = 40'h37_00_19_00_51;
  localparam logic [39:0] FRAME_C = 40'h41_05_1E_03_67;
  localparam logic [39:0] FRAME_E = 40'h2A_09_17_02_4C;

  // Open-drain wire: either side pulling low wins.
  assign dht_in = sensor_q & ~dht_oe;

  always #5 clk = ~clk;

  dht11_frame_reader #(
    .CLKS_PER_US   (2),
    .START_LOW_US  (100),
    .TIMEOUT_US    (200),
    .BIT_THRESH_US (48)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .dht_in       (dht_in),
    .dht_oe       (dht_oe),
    .busy         (busy),
    .data_valid   (data_valid),
    .hum_int      (hum_int),
    .hum_dec      (hum_dec),
    .temp_int     (temp_int),
    .temp_dec     (temp_dec),
    .checksum_err (checksum_err),
    .timeout_err  (timeout_err)
  );

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      dv_cnt     <= dv_cnt + 1;
      busy_at_dv <= busy;
    end
    if (checksum_err === 1'b1) ce_cnt <= ce_cnt + 1;
    if (timeout_err === 1'b1)  to_cnt <= to_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic us(input int n);
    repeat (2 * n) @(negedge clk);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_bytes(input string tag, input logic [31:0] exp);
    check({tag, "_hum_int"},  32'(hum_int),  32'(exp[31:24]));
    check({tag, "_hum_dec"},  32'(hum_dec),  32'(exp[23:16]));
    check({tag, "_temp_int"}, 32'(temp_int), 32'(exp[15:8]));
    check({tag, "_temp_dec"}, 32'(temp_dec), 32'(exp[7:0]));
  endtask

  // Sensor model: response 80/80 us, then per bit 50 us low and 26/70 us high.
  task automatic sensor_reply(input logic [39:0] f, input int stall_bit,
                              input int poke_bit, input int reset_bit);
    int n;
    n = 0;
    while (dht_oe !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("oe_release", 32'(dht_oe), 32'd0);
    us(30);
    sensor_q = 1'b0; us(80);
    sensor_q = 1'b1; us(80);
    for (int i = 0; i < 40; i++) begin
      sensor_q = 1'b0;
      us(25);
      if (i == poke_bit) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      us(25);
      sensor_q = 1'b1;
      if (i == stall_bit) begin
        us(250);
        return;
      end
      if (i == reset_bit) begin
        us(10);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_oe",   32'(dht_oe), 32'd0);
        check("rst_async_busy", 32'(busy),   32'd0);
        check_bytes("rst_async", 32'h00_00_00_00);
        return;
      end
      us(f[39-i] ? 70 : 26);
    end
    sensor_q = 1'b0;
    us(50);
    sensor_q = 1'b1;
  endtask

  initial begin
    int dv0, ce0, to0, n;

    clks(3);
    check("rst_oe",         32'(dht_oe),       32'd0);
    check("rst_busy",       32'(busy),         32'd0);
    check("rst_data_valid", 32'(data_valid),   32'd0);
    check("rst_cksum_err",  32'(checksum_err), 32'd0);
    check("rst_tmo_err",    32'(timeout_err),  32'd0);
    check_bytes("rst", 32'h00_00_00_00);
    rst_n = 1'b1;
    clks(3);
    check("idle_busy", 32'(busy), 32'd0);

    // Good frame 55.0 %RH / 25.0 C.
    dv0 = dv_cnt; ce0 = ce_cnt;
    do_start();
    check("start_busy", 32'(busy),   32'd1);
    check("start_oe",   32'(dht_oe), 32'd1);
    sensor_reply(FRAME_A, -1, -1, -1);
    clks(10);
    check("good_dv_pulses", dv_cnt - dv0, 1);
    check("good_busy_at_dv", 32'(busy_at_dv), 32'd0);
    check("good_no_cksum_err", ce_cnt - ce0, 0);
    check_bytes("good", 32'h37_00_19_00);

    // Same frame, corrupted checksum.
    dv0 = dv_cnt; ce0 = ce_cnt;
    do_start();
    sensor_reply(FRAME_B, -1, -1, -1);
    clks(10);
    check("bad_cksum_pulses", ce_cnt - ce0, 1);
    check("bad_dv_pulses", dv_cnt - dv0, 0);
    check("bad_busy", 32'(busy), 32'd0);
    check_bytes("bad_hold", 32'h37_00_19_00);

    // No sensor: 200 clocks of start pulse, then a 200 us response timeout.
    dv0 = dv_cnt; to0 = to_cnt;
    do_start();
    n = 0;
    while (dht_oe === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("nosensor_oe_clocks", n, 200);
    n = 0;
    while (timeout_err !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("nosensor_tmo_latency", n, 401);
    clks(5);
    check("nosensor_tmo_pulses", to_cnt - to0, 1);
    check("nosensor_busy", 32'(busy), 32'd0);
    check("nosensor_dv", dv_cnt - dv0, 0);
    check_bytes("nosensor_hold", 32'h37_00_19_00);

    // Sensor stalls high during bit 17.
    dv0 = dv_cnt; to0 = to_cnt;
    do_start();
    sensor_reply(FRAME_A, 17, -1, -1);
    clks(10);
    check("stall_tmo_pulses", to_cnt - to0, 1);
    check("stall_busy", 32'(busy), 32'd0);
    check("stall_dv", dv_cnt - dv0, 0);

    // Next frame decodes cleanly; a start during bit 5 is ignored.
    dv0 = dv_cnt; ce0 = ce_cnt;
    do_start();
    sensor_reply(FRAME_C, -1, 5, -1);
    clks(10);
    check("poke_dv_pulses", dv_cnt - dv0, 1);
    check("poke_cksum_err", ce_cnt - ce0, 0);
    check("poke_busy", 32'(busy), 32'd0);
    check("poke_oe", 32'(dht_oe), 32'd0);
    check_bytes("poke", 32'h41_05_1E_03);

    // Reset during bit 20, then a fresh frame.
    do_start();
    sensor_reply(FRAME_A, -1, -1, 20);
    clks(3);
    rst_n = 1'b1;
    clks(5);
    dv0 = dv_cnt;
    do_start();
    sensor_reply(FRAME_E, -1, -1, -1);
    clks(10);
    check("post_rst_dv_pulses", dv_cnt - dv0, 1);
    check_bytes("post_rst", 32'h2A_09_17_02);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
